// File: rtl/ami_pkg.sv
// Shared definitions for the run-parity line coder and its receive-side decoder.
package ami_pkg;

   // Line symbol encoding
   localparam logic [1:0] SYM_ZERO = 2'b00;
   localparam logic [1:0] SYM_POS  = 2'b01;
   localparam logic [1:0] SYM_NEG  = 2'b10;
   localparam logic [1:0] SYM_ILL  = 2'b11;

   // Ones-run counter width shared with the coder
   localparam int unsigned CNT_W_DEF = 32;

   // Receiver synchronisation states
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCK   = 2'd2
   } state_e;

endpackage

// File: rtl/ami_run_decoder_if.sv
// Symbol input and decoded status bundle of the run-parity decoder.
interface ami_run_decoder_if #(
   parameter int unsigned ECNT_W = 16
);
   logic [1:0]        code_i;
   logic              clr_i;
   logic              bit_o;
   logic              valid_o;
   logic              lock_o;
   logic              viol_o;
   logic              illegal_o;
   logic [ECNT_W-1:0] err_cnt_o;

   modport master (
      output code_i, clr_i,
      input  bit_o, valid_o, lock_o, viol_o, illegal_o, err_cnt_o
   );

   modport slave (
      input  code_i, clr_i,
      output bit_o, valid_o, lock_o, viol_o, illegal_o, err_cnt_o
   );
endinterface

// File: rtl/ami_polarity_checker.sv
// Tracks the coder's ones-run counter and reference polarity; flags nonzero
// symbols whose polarity disagrees with the level the coder should have sent.
module ami_polarity_checker
   import ami_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] code_i,
   input  logic       check_en_i,
   output logic       viol_o
);

   logic [CNT_W-1:0] run_cnt_q, run_cnt_d, run_inc;
   logic [1:0]       ref_q, ref_d, expected;

   // Next run count / reference polarity and the expected-level compare
   always_comb begin
      run_inc   = run_cnt_q + CNT_W'(1);
      expected  = (^run_cnt_q) ? ~ref_q : ref_q;
      run_cnt_d = run_cnt_q;
      ref_d     = ref_q;
      viol_o    = 1'b0;
      case (code_i)
         SYM_ZERO: run_cnt_d = (&run_inc) ? '0 : run_inc;
         SYM_POS, SYM_NEG: begin
            viol_o    = check_en_i && (code_i != expected);
            ref_d     = code_i;
            run_cnt_d = '0;
         end
         default: run_cnt_d = '0;
      endcase
   end

   // Checker state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         run_cnt_q <= '0;
         ref_q     <= SYM_POS;
      end else begin
         run_cnt_q <= run_cnt_d;
         ref_q     <= ref_d;
      end
   end

endmodule

// File: rtl/ami_run_decoder.sv
// Run-parity line decoder: recovers bits, flags violations / illegal symbols
// and runs HUNT/VERIFY/LOCK synchronisation with a saturating error count.
module ami_run_decoder
   import ami_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned LOCK_N    = 4,
   parameter int unsigned ERR_LIMIT = 3,
   parameter int unsigned GOOD_RUN  = 8,
   parameter int unsigned ECNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   ami_run_decoder_if.slave bus
);

   localparam int unsigned GC_MAX = (LOCK_N > GOOD_RUN) ? LOCK_N : GOOD_RUN;
   localparam int unsigned GC_W   = $clog2(GC_MAX + 1);
   localparam int unsigned PE_W   = $clog2(ERR_LIMIT + 1);

   state_e            state_q, state_d;
   logic [GC_W-1:0]   good_cnt_q, good_cnt_d;
   logic [PE_W-1:0]   pend_err_q, pend_err_d;
   logic [ECNT_W-1:0] err_cnt_q, err_cnt_d;
   logic              bit_q, bit_d, valid_q, valid_d;
   logic              viol_q, viol_d, illegal_q, illegal_d;
   logic              viol_now, ill_now, nz_now, err_now, good_now;

   ami_polarity_checker #(.CNT_W(CNT_W)) u_pol (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .code_i     (bus.code_i),
      .check_en_i (state_q != HUNT),
      .viol_o     (viol_now)
   );

   // Symbol classification, synchronisation FSM and error accounting
   always_comb begin
      ill_now  = (bus.code_i == SYM_ILL);
      nz_now   = (bus.code_i == SYM_POS) || (bus.code_i == SYM_NEG);
      err_now  = (state_q != HUNT) && (viol_now || ill_now);
      good_now = nz_now && !viol_now;

      bit_d      = (bus.code_i == SYM_ZERO);
      valid_d    = 1'b1;
      viol_d     = viol_now;
      illegal_d  = ill_now;
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      pend_err_d = pend_err_q;

      if (bus.clr_i)
         err_cnt_d = '0;
      else if (err_now && !(&err_cnt_q))
         err_cnt_d = err_cnt_q + ECNT_W'(1);
      else
         err_cnt_d = err_cnt_q;

      case (state_q)
         HUNT: begin
            if (nz_now) begin
               state_d    = VERIFY;
               good_cnt_d = '0;
            end
         end
         VERIFY: begin
            if (err_now)
               good_cnt_d = '0;
            else if (good_now) begin
               if (good_cnt_q + GC_W'(1) == GC_W'(LOCK_N)) begin
                  state_d    = LOCK;
                  good_cnt_d = '0;
                  pend_err_d = '0;
               end else
                  good_cnt_d = good_cnt_q + GC_W'(1);
            end
         end
         LOCK: begin
            if (err_now) begin
               good_cnt_d = '0;
               if (pend_err_q + PE_W'(1) == PE_W'(ERR_LIMIT)) begin
                  state_d    = HUNT;
                  pend_err_d = '0;
               end else
                  pend_err_d = pend_err_q + PE_W'(1);
            end else if (good_now) begin
               if (good_cnt_q + GC_W'(1) == GC_W'(GOOD_RUN)) begin
                  good_cnt_d = '0;
                  pend_err_d = '0;
               end else
                  good_cnt_d = good_cnt_q + GC_W'(1);
            end
         end
         default: begin
            state_d    = HUNT;
            good_cnt_d = '0;
            pend_err_d = '0;
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= HUNT;
         good_cnt_q <= '0;
         pend_err_q <= '0;
         err_cnt_q  <= '0;
         bit_q      <= 1'b0;
         valid_q    <= 1'b0;
         viol_q     <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         good_cnt_q <= good_cnt_d;
         pend_err_q <= pend_err_d;
         err_cnt_q  <= err_cnt_d;
         bit_q      <= bit_d;
         valid_q    <= valid_d;
         viol_q     <= viol_d;
         illegal_q  <= illegal_d;
      end
   end

   assign bus.bit_o     = bit_q;
   assign bus.valid_o   = valid_q;
   assign bus.lock_o    = (state_q == LOCK);
   assign bus.viol_o    = viol_q;
   assign bus.illegal_o = illegal_q;
   assign bus.err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_ami_run_decoder.sv
// Directed bench for ami_run_decoder: a vector table on a 32-bit-counter
// instance, plus wrap and asynchronous-reset sequences alongside a 3-bit one.
module tb_ami_run_decoder;

   typedef struct {
      logic [1:0]  code;
      logic        clr;
      logic        bt;
      logic        vi;
      logic        il;
      logic        lk;
      logic [15:0] err;
   } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   vec_t vq[$];

   ami_run_decoder_if #(.ECNT_W(16)) bus32 ();
   ami_run_decoder_if #(.ECNT_W(16)) bus3 ();

   ami_run_decoder #(.CNT_W(32), .LOCK_N(4), .ERR_LIMIT(3), .GOOD_RUN(8), .ECNT_W(16)) u32 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus32)
   );

   ami_run_decoder #(.CNT_W(3), .LOCK_N(4), .ERR_LIMIT(3), .GOOD_RUN(8), .ECNT_W(16)) u3 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input logic [1:0] c, input logic cl);
      bus32.code_i = c;
      bus3.code_i  = c;
      bus32.clr_i  = cl;
      bus3.clr_i   = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [1:0] c, input logic cl, input logic b, input logic v,
                      input logic i, input logic l, input logic [15:0] e);
      vq.push_back('{code: c, clr: cl, bt: b, vi: v, il: i, lk: l, err: e});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " bit"}, 32'(bus32.bit_o), 0);
      chk({tag, " valid"}, 32'(bus32.valid_o), 0);
      chk({tag, " lock"}, 32'(bus32.lock_o), 0);
      chk({tag, " viol"}, 32'(bus32.viol_o), 0);
      chk({tag, " illegal"}, 32'(bus32.illegal_o), 0);
      chk({tag, " err_cnt"}, 32'(bus32.err_cnt_o), 0);
      chk({tag, " lock3"}, 32'(bus3.lock_o), 0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus32.code_i = 2'b00;
      bus3.code_i  = 2'b00;
      bus32.clr_i  = 1'b0;
      bus3.clr_i   = 1'b0;

      //   code  clr bit viol ill lock err
      add(2'b01, 0, 0, 0, 0, 0, 0);   // HUNT seed
      add(2'b00, 0, 1, 0, 0, 0, 0);
      add(2'b10, 0, 0, 0, 0, 0, 0);   // run 1 -> opposite polarity
      add(2'b01, 0, 0, 1, 0, 0, 1);   // run 0 -> same polarity expected
      add(2'b00, 0, 1, 0, 0, 0, 1);
      add(2'b00, 0, 1, 0, 0, 0, 1);
      add(2'b10, 0, 0, 0, 0, 0, 1);   // run 2: popcount odd
      add(2'b00, 0, 1, 0, 0, 0, 1);
      add(2'b00, 0, 1, 0, 0, 0, 1);
      add(2'b00, 0, 1, 0, 0, 0, 1);
      add(2'b10, 0, 0, 0, 0, 0, 1);   // run 3: popcount even
      add(2'b00, 0, 1, 0, 0, 0, 1);
      add(2'b00, 0, 1, 0, 0, 0, 1);
      add(2'b10, 0, 0, 1, 0, 0, 2);   // run 2 with same polarity -> viol
      add(2'b00, 0, 1, 0, 0, 0, 2);
      add(2'b01, 0, 0, 0, 0, 0, 2);
      add(2'b00, 0, 1, 0, 0, 0, 2);
      add(2'b10, 0, 0, 0, 0, 0, 2);
      add(2'b00, 0, 1, 0, 0, 0, 2);
      add(2'b01, 0, 0, 0, 0, 0, 2);
      add(2'b00, 0, 1, 0, 0, 0, 2);
      add(2'b10, 0, 0, 0, 0, 1, 2);   // 4th good -> LOCK
      add(2'b00, 1, 1, 0, 0, 1, 0);   // clear
      add(2'b11, 0, 0, 0, 1, 1, 1);
      add(2'b11, 0, 0, 0, 1, 1, 2);
      add(2'b11, 0, 0, 0, 1, 0, 3);   // 3rd error -> HUNT
      add(2'b11, 0, 0, 0, 1, 0, 3);   // not counted in HUNT
      add(2'b00, 1, 1, 0, 0, 0, 0);
      add(2'b10, 0, 0, 0, 0, 0, 0);   // seed
      add(2'b11, 1, 0, 0, 1, 0, 0);   // clear beats coincident error
      add(2'b11, 0, 0, 0, 1, 0, 1);
      add(2'b10, 0, 0, 0, 0, 0, 1);
      add(2'b10, 0, 0, 0, 0, 0, 1);
      add(2'b10, 0, 0, 0, 0, 0, 1);
      add(2'b10, 0, 0, 0, 0, 1, 1);   // LOCK
      add(2'b11, 0, 0, 0, 1, 1, 2);
      add(2'b11, 0, 0, 0, 1, 1, 3);
      for (int k = 0; k < 8; k++) add(2'b10, 0, 0, 0, 0, 1, 3);  // good run clears pending
      add(2'b11, 0, 0, 0, 1, 1, 4);
      add(2'b11, 0, 0, 0, 1, 1, 5);
      add(2'b11, 0, 0, 0, 1, 0, 6);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         tick(vq[i].code, vq[i].clr);
         chk($sformatf("v%0d bit", i), 32'(bus32.bit_o), 32'(vq[i].bt));
         chk($sformatf("v%0d valid", i), 32'(bus32.valid_o), 1);
         chk($sformatf("v%0d viol", i), 32'(bus32.viol_o), 32'(vq[i].vi));
         chk($sformatf("v%0d illegal", i), 32'(bus32.illegal_o), 32'(vq[i].il));
         chk($sformatf("v%0d lock", i), 32'(bus32.lock_o), 32'(vq[i].lk));
         chk($sformatf("v%0d err_cnt", i), 32'(bus32.err_cnt_o), 32'(vq[i].err));
      end

      // Counter wrap: 3-bit counter wraps at 7 zeros, 32-bit one sees run 7
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(2'b01, 0);
      for (int k = 0; k < 7; k++) tick(2'b00, 0);
      tick(2'b01, 0);
      chk("wrap viol3", 32'(bus3.viol_o), 0);
      chk("wrap viol32", 32'(bus32.viol_o), 1);
      chk("wrap err3", 32'(bus3.err_cnt_o), 0);
      chk("wrap err32", 32'(bus32.err_cnt_o), 1);
      for (int k = 0; k < 3; k++) tick(2'b01, 0);
      chk("lock3 early", 32'(bus3.lock_o), 1);
      chk("lock32 late", 32'(bus32.lock_o), 0);
      tick(2'b01, 0);
      chk("lock32", 32'(bus32.lock_o), 1);
      tick(2'b00, 0);
      chk("pre-rst bit", 32'(bus32.bit_o), 1);

      // Asynchronous reset between edges while locked
      #3;
      rst = 1'b1;
      #1;
      chk_all_zero("async rst");
      @(posedge clk);
      #2;
      rst = 1'b0;
      tick(2'b10, 0);
      chk("post-rst valid", 32'(bus32.valid_o), 1);
      chk("post-rst viol", 32'(bus32.viol_o), 0);
      chk("post-rst lock", 32'(bus32.lock_o), 0);
      tick(2'b10, 0);
      chk("post-rst lock2", 32'(bus32.lock_o), 0);
      chk("post-rst err", 32'(bus32.err_cnt_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
